// File: rtl/tdt_dm_pkg.sv
// Shared debug-module definitions for the System Bus Access front-end.
// Holds the DMI register addresses, sberror codes, the SBA FSM state type
// and the bit positions of the fields inside sbcs.
package tdt_dm_pkg;

  // DMI register addresses
  localparam logic [6:0] DMI_SBCS       = 7'h38;
  localparam logic [6:0] DMI_SBADDRESS0 = 7'h39;
  localparam logic [6:0] DMI_SBDATA0    = 7'h3c;
  localparam logic [6:0] DMI_SBDATA1    = 7'h3d;

  // sberror codes
  localparam logic [2:0] SBERR_NONE  = 3'd0;
  localparam logic [2:0] SBERR_BUS   = 3'd2;
  localparam logic [2:0] SBERR_ALIGN = 3'd3;
  localparam logic [2:0] SBERR_SIZE  = 3'd4;

  // sbcs field positions
  localparam int unsigned SBCS_VERSION_LSB = 29;
  localparam int unsigned SBCS_BUSYERROR   = 22;
  localparam int unsigned SBCS_BUSY        = 21;
  localparam int unsigned SBCS_READONADDR  = 20;
  localparam int unsigned SBCS_ACCESS_LSB  = 17;
  localparam int unsigned SBCS_AUTOINC     = 16;
  localparam int unsigned SBCS_READONDATA  = 15;
  localparam int unsigned SBCS_ERROR_LSB   = 12;
  localparam int unsigned SBCS_ASIZE_LSB   = 5;
  localparam int unsigned SBCS_ACCESS64    = 3;
  localparam int unsigned SBCS_ACCESS32    = 2;

  localparam logic [2:0] SBA_VERSION = 3'd1;

  typedef enum logic [1:0] {
    SBA_IDLE,
    SBA_ISSUE,
    SBA_WAIT
  } sba_state_e;

endpackage

// File: rtl/tdt_sba_ctrl_if.sv
// Command/response bus between the SBA register front-end and the SBA
// AXI master.
//   wr_data/wr_flg/wr_addr/wr_size/wr_vld : command (front-end -> master)
//   rd_data/axi_wr_ready/sba_error        : completion (master -> front-end)
// modport master: the front-end side; modport slave: the AXI master side.
interface tdt_sba_ctrl_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
);
  logic [DW-1:0] wr_data;
  logic          wr_flg;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_size;
  logic          wr_vld;
  logic [DW-1:0] rd_data;
  logic          axi_wr_ready;
  logic          sba_error;

  modport master (
    output wr_data, wr_flg, wr_addr, wr_size, wr_vld,
    input  rd_data, axi_wr_ready, sba_error
  );

  modport slave (
    input  wr_data, wr_flg, wr_addr, wr_size, wr_vld,
    output rd_data, axi_wr_ready, sba_error
  );
endinterface

// File: rtl/tdt_sba_ctrl.sv
// System Bus Access register front-end of the debug module.
// Holds sbcs, sbaddress0, sbdata0 and sbdata1, decodes DMI accesses into
// single-beat bus commands and captures returned data / bus errors.
// Ports:
//   mclk, mreset   : clock, synchronous active-high reset
//   axim_clk_en    : downstream clock-enable qualifier
//   reg_sel/reg_wr/reg_addr/reg_wdata : DMI register access (one-cycle strobe)
//   reg_rdata      : combinational DMI read data (0 for unmapped addresses)
//   bus            : command/completion interface to the SBA AXI master
module tdt_sba_ctrl
  import tdt_dm_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
) (
  input  logic        mclk,
  input  logic        mreset,
  input  logic        axim_clk_en,
  input  logic        reg_sel,
  input  logic        reg_wr,
  input  logic [6:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  tdt_sba_ctrl_if.master bus
);

  sba_state_e state, state_nxt;

  // sbcs fields
  logic          sbbusyerror;
  logic          sbreadonaddr;
  logic [2:0]    sbaccess;
  logic          sbautoincrement;
  logic          sbreadondata;
  logic [2:0]    sberror;
  logic          sbbusy;

  logic [AW-1:0] sbaddress0;
  logic [31:0]   sbdata0;
  logic [31:0]   sbdata1;

  // command latched at trigger time
  logic [DW-1:0] cmd_data;
  logic          cmd_flg;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;

  logic          acc_sbcs, acc_addr, acc_data0, acc_data1, acc_dreg;
  logic          busy_viol, dreg_write;
  logic          trig_ok, trig_rd_addr, trig_wr, trig_rd_data, trigger;
  logic          size_ok, misaligned, issue_go, done;
  logic [AW-1:0] trig_addr, align_mask;
  logic [63:0]   trig_data64, rd64;
  logic [31:0]   sbcs_val;

  // ---------------------------------------------------------------------
  // Access decode and trigger evaluation
  // ---------------------------------------------------------------------
  always_comb begin
    acc_sbcs  = reg_sel && (reg_addr == DMI_SBCS);
    acc_addr  = reg_sel && (reg_addr == DMI_SBADDRESS0);
    acc_data0 = reg_sel && (reg_addr == DMI_SBDATA0);
    acc_data1 = reg_sel && (reg_addr == DMI_SBDATA1);
    acc_dreg  = acc_addr || acc_data0 || acc_data1;

    busy_viol  = sbbusy && acc_dreg;
    dreg_write = !sbbusy && reg_wr;

    trig_ok      = !sbbusy && (sberror == SBERR_NONE) && !sbbusyerror;
    trig_rd_addr = trig_ok && acc_addr && reg_wr && sbreadonaddr;
    trig_wr      = trig_ok && acc_data0 && reg_wr;
    trig_rd_data = trig_ok && acc_data0 && !reg_wr && sbreadondata;
    trigger      = trig_rd_addr || trig_wr || trig_rd_data;

    // The command must carry the value written in this same cycle.
    trig_addr   = trig_rd_addr ? AW'(reg_wdata) : sbaddress0;
    trig_data64 = {sbdata1, (trig_wr ? reg_wdata : sbdata0)};

    size_ok    = (sbaccess == 3'd2) || ((sbaccess == 3'd3) && (DW == 64));
    align_mask = (AW'(1) << sbaccess) - AW'(1);
    misaligned = |(trig_addr & align_mask);
    issue_go   = trigger && size_ok && !misaligned;

    done = (state == SBA_WAIT) && bus.axi_wr_ready && axim_clk_en;
    rd64 = 64'(bus.rd_data);
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (mreset) state <= SBA_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      SBA_IDLE:  if (issue_go)    state_nxt = SBA_ISSUE;
      // Leave on the first enabled cycle so wr_vld is seen exactly once.
      SBA_ISSUE: if (axim_clk_en) state_nxt = SBA_WAIT;
      SBA_WAIT:  if (done)        state_nxt = SBA_IDLE;
      default:                    state_nxt = SBA_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.wr_vld = (state == SBA_ISSUE);
    sbbusy     = (state != SBA_IDLE);
  end

  assign bus.wr_data = cmd_data;
  assign bus.wr_flg  = cmd_flg;
  assign bus.wr_addr = cmd_addr;
  assign bus.wr_size = cmd_size;

  // ---------------------------------------------------------------------
  // Register file and command latch
  // ---------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (mreset) begin
      sbbusyerror     <= 1'b0;
      sbreadonaddr    <= 1'b0;
      sbaccess        <= 3'd2;
      sbautoincrement <= 1'b0;
      sbreadondata    <= 1'b0;
      sberror         <= SBERR_NONE;
      sbaddress0      <= '0;
      sbdata0         <= '0;
      sbdata1         <= '0;
      cmd_data        <= '0;
      cmd_flg         <= 1'b0;
      cmd_addr        <= '0;
      cmd_size        <= '0;
    end else begin
      if (acc_sbcs && reg_wr) begin
        sbreadonaddr    <= reg_wdata[SBCS_READONADDR];
        sbaccess        <= reg_wdata[SBCS_ACCESS_LSB +: 3];
        sbautoincrement <= reg_wdata[SBCS_AUTOINC];
        sbreadondata    <= reg_wdata[SBCS_READONDATA];
        if (reg_wdata[SBCS_BUSYERROR])         sbbusyerror <= 1'b0;
        if (|reg_wdata[SBCS_ERROR_LSB +: 3])   sberror     <= SBERR_NONE;
      end

      if (busy_viol) sbbusyerror <= 1'b1;

      if (dreg_write) begin
        if (acc_addr)  sbaddress0 <= AW'(reg_wdata);
        if (acc_data0) sbdata0    <= reg_wdata;
        if (acc_data1) sbdata1    <= reg_wdata;
      end

      if (trigger && !size_ok)        sberror <= SBERR_SIZE;
      else if (trigger && misaligned) sberror <= SBERR_ALIGN;

      if (issue_go) begin
        cmd_data <= trig_data64[DW-1:0];
        cmd_flg  <= trig_wr;
        cmd_addr <= trig_addr;
        cmd_size <= sbaccess;
      end

      // Placed last so a bus error overrides a same-cycle sberror W1C.
      if (done) begin
        if (bus.sba_error) begin
          sberror <= SBERR_BUS;
        end else begin
          if (!cmd_flg) begin
            sbdata0 <= rd64[31:0];
            if (cmd_size == 3'd3) sbdata1 <= rd64[63:32];
          end
          if (sbautoincrement) sbaddress0 <= sbaddress0 + (AW'(1) << cmd_size);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // DMI read mux
  // ---------------------------------------------------------------------
  always_comb begin
    sbcs_val = '0;
    sbcs_val[SBCS_VERSION_LSB +: 3] = SBA_VERSION;
    sbcs_val[SBCS_BUSYERROR]        = sbbusyerror;
    sbcs_val[SBCS_BUSY]             = sbbusy;
    sbcs_val[SBCS_READONADDR]       = sbreadonaddr;
    sbcs_val[SBCS_ACCESS_LSB +: 3]  = sbaccess;
    sbcs_val[SBCS_AUTOINC]          = sbautoincrement;
    sbcs_val[SBCS_READONDATA]       = sbreadondata;
    sbcs_val[SBCS_ERROR_LSB +: 3]   = sberror;
    sbcs_val[SBCS_ASIZE_LSB +: 7]   = 7'(AW);
    sbcs_val[SBCS_ACCESS64]         = (DW == 64);
    sbcs_val[SBCS_ACCESS32]         = 1'b1;

    reg_rdata = '0;
    unique case (reg_addr)
      DMI_SBCS:       reg_rdata = sbcs_val;
      DMI_SBADDRESS0: reg_rdata = 32'(sbaddress0);
      DMI_SBDATA0:    reg_rdata = sbdata0;
      DMI_SBDATA1:    reg_rdata = sbdata1;
      default:        reg_rdata = '0;
    endcase
  end

endmodule
